// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: reset and chip-enable
// levels, the default instruction address width, and the fetch state encoding.
package pc_gen_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int INST_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator for the instruction fetch stage. Holds the fetch
// address, advances it on each accepted fetch, follows branch/jump redirects
// and parks in HALT on a halt request or a misaligned redirect target.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_W,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              fetch_valid,
    output logic              misalign_err
);

    localparam int ALIGN_W = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_BYTES);

    pc_state_t         state;
    pc_state_t         state_next;
    logic [ADDR_W-1:0] pc_next;
    logic              ce_next;
    logic              err_next;
    logic              target_aligned;
    logic              handshake;

    assign fetch_valid    = (state == RUN) && !stall;
    assign handshake      = fetch_valid && fetch_ready;
    assign target_aligned = (redir_target[ALIGN_W-1:0] == '0);

    // Next-state and next-PC selection: redirect beats halt, halt beats an
    // accepted fetch, and anything else holds the current PC.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ce_next    = ce;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
                ce_next    = CHIP_ENABLE;
            end
            RUN, HALT: begin
                ce_next = CHIP_ENABLE;
                if (redir_valid) begin
                    if (target_aligned) begin
                        pc_next    = redir_target;
                        state_next = RUN;
                    end else begin
                        err_next   = 1'b1;
                        state_next = HALT;
                    end
                end else if (halt && (state == RUN)) begin
                    state_next = HALT;
                end else if (handshake) begin
                    pc_next = pc + PC_STEP;
                end
            end
            default: begin
                state_next = IDLE;
                ce_next    = CHIP_DISABLE;
            end
        endcase
    end

    // Single register stage for pc, ce, state and the error pulse; reset wins
    // over every other input on the same edge.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc           <= RESET_VEC;
            ce           <= CHIP_DISABLE;
            state        <= IDLE;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_next;
            ce           <= ce_next;
            state        <= state_next;
            misalign_err <= err_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with a queue-based scoreboard. Each vector
// carries the outputs expected during the cycle it is applied in: the
// registered outputs produced by the previous edge, plus fetch_valid.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        ce;
    logic        fetch_valid;
    logic        misalign_err;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        halt;
        logic        rv;
        logic [31:0] tgt;
        logic        fr;
        logic [31:0] epc;
        logic        ece;
        logic        efv;
        logic        eerr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        ce;
        logic        fv;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;
    bit   done            = 1'b0;

    pc_gen #(
        .ADDR_W    (32),
        .INST_BYTES(4),
        .RESET_VEC (32'h0000_1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .ce          (ce),
        .fetch_valid (fetch_valid),
        .misalign_err(misalign_err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic h, input logic rv,
                       input logic [31:0] tgt, input logic fr,
                       input logic [31:0] epc, input logic ece, input logic efv,
                       input logic eerr);
        vec_t v;
        v.rst = r;  v.stall = s; v.halt = h; v.rv = rv; v.tgt = tgt; v.fr = fr;
        v.epc = epc; v.ece = ece; v.efv = efv; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    // Drive one vector's inputs and queue what the monitor should see.
    task automatic applyStimulus(input int idx);
        exp_t e;
        rst          = vecs[idx].rst;
        stall        = vecs[idx].stall;
        halt         = vecs[idx].halt;
        redir_valid  = vecs[idx].rv;
        redir_target = vecs[idx].tgt;
        fetch_ready  = vecs[idx].fr;
        e.idx = idx;
        e.pc  = vecs[idx].epc;
        e.ce  = vecs[idx].ece;
        e.fv  = vecs[idx].efv;
        e.err = vecs[idx].eerr;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors_applied++;
        if (pc !== e.pc) begin
            miscompares++;
            $display("[TB] FAIL v%0d pc: got %h expected %h", e.idx, pc, e.pc);
        end
        if (ce !== e.ce) begin
            miscompares++;
            $display("[TB] FAIL v%0d ce: got %b expected %b", e.idx, ce, e.ce);
        end
        if (fetch_valid !== e.fv) begin
            miscompares++;
            $display("[TB] FAIL v%0d fetch_valid: got %b expected %b", e.idx, fetch_valid, e.fv);
        end
        if (misalign_err !== e.err) begin
            miscompares++;
            $display("[TB] FAIL v%0d misalign_err: got %b expected %b", e.idx, misalign_err, e.err);
        end
    endtask

    // Monitor: compares outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    // Stimulus: vectors applied 1 unit after each rising edge.
    initial begin
        //   rst stl hlt rv  target         fr   pc             ce fv err
        add(1, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1000, 0, 0, 0);
        add(1, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1000, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_1000, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_1000, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_1004, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1008, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1008, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1008, 1, 1, 0);
        add(0, 1, 0, 0, 32'h0000_0000, 1, 32'h0000_1008, 1, 0, 0);
        add(0, 1, 0, 0, 32'h0000_0000, 1, 32'h0000_1008, 1, 0, 0);
        add(0, 1, 0, 1, 32'h0000_2000, 1, 32'h0000_1008, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_2000, 1, 1, 0);
        add(0, 0, 0, 1, 32'h0000_2100, 1, 32'h0000_2004, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_2100, 1, 1, 0);
        add(0, 0, 0, 1, 32'h0000_2002, 1, 32'h0000_2104, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_2104, 1, 0, 1);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_2104, 1, 0, 0);
        add(0, 0, 0, 1, 32'h0000_3000, 1, 32'h0000_2104, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_3000, 1, 1, 0);
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_3004, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 1, 1, 0);
        add(0, 0, 1, 0, 32'h0000_0000, 1, 32'h0000_0004, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_0004, 1, 0, 0);
        add(0, 0, 0, 1, 32'h0000_5000, 1, 32'h0000_0004, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_5000, 1, 1, 0);
        add(1, 0, 1, 1, 32'h0000_6000, 1, 32'h0000_5004, 1, 1, 0);
        add(0, 0, 0, 1, 32'h0000_7000, 1, 32'h0000_1000, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 1, 32'h0000_1000, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1004, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_1004, 1, 1, 0);

        rst          = 1'b1;
        stall        = 1'b0;
        halt         = 1'b0;
        redir_valid  = 1'b0;
        redir_target = '0;
        fetch_ready  = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(i);
        end
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #100000;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL watchdog: got timeout expected completion");
            $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
            $finish;
        end
    end

endmodule
